// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter: FSM state
// encodings, access size encodings, bus owner, and the streak-counter width.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } arb_owner_e;

  // Width of the starvation streak counter: enough to hold STARVE_LIMIT,
  // never narrower than one bit (STARVE_LIMIT = 0 still needs a register).
  function automatic int streak_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational chooser between the fetch and load/store ports. Data wins
// unless inst has waited through STARVE_LIMIT consecutive data grants.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int SW           = streak_width(STARVE_LIMIT)
) (
  input  logic          inst_req,
  input  logic          data_req,
  input  logic [SW-1:0] streak,
  output logic          grant_inst,
  output logic          grant_data
);

  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic inst_turn;

  // A zero limit disables the starvation override entirely.
  assign inst_turn  = (STARVE_LIMIT != 0) && (streak == LIMIT);
  assign grant_inst = inst_req && (!data_req || inst_turn);
  assign grant_data = data_req && !grant_inst;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and load/store.
// One outstanding access: IDLE -> ADDR (bus_req) -> DATA (wait data_ok),
// with ADDR returning straight to IDLE when the bus accepts and answers in
// the same cycle. Request fields are latched into bus registers at grant.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch port
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  // load/store port
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [3:0]    data_wstrb,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  // bus bridge side
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_wstrb,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy
);

  localparam int            SW    = streak_width(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_e    state_q,     state_d;
  arb_owner_e    owner_q,     owner_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic          bus_wr_q,    bus_wr_d;
  logic [1:0]    bus_size_q,  bus_size_d;
  logic [AW-1:0] bus_addr_q,  bus_addr_d;
  logic [3:0]    bus_wstrb_q, bus_wstrb_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic grant_inst, grant_data;
  logic addr_ok_raw, data_ok_raw;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SW           (SW)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .streak     (streak_q),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  // Arbitration, field latching, and bus handshake sequencing.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    bus_req     = 1'b0;
    addr_ok_raw = 1'b0;
    data_ok_raw = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // A fetch that is not waiting cannot be starved.
        if (!inst_req) streak_d = '0;
        if (grant_data) begin
          owner_d     = OWNER_DATA;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_addr_d  = data_addr;
          bus_wstrb_d = data_wstrb;
          bus_wdata_d = data_wdata;
          state_d     = ARB_ADDR;
          if (inst_req && (streak_q != LIMIT)) streak_d = streak_q + SW'(1);
        end else if (grant_inst) begin
          owner_d     = OWNER_INST;
          bus_wr_d    = 1'b0;
          bus_size_d  = SIZE_W;
          bus_addr_d  = inst_addr;
          bus_wstrb_d = 4'b0000;
          bus_wdata_d = '0;
          streak_d    = '0;
          state_d     = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        bus_req     = 1'b1;
        addr_ok_raw = bus_addr_ok;
        // data_ok without addr_ok is not meaningful in this phase.
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            data_ok_raw = 1'b1;
            state_d     = ARB_IDLE;
          end else begin
            state_d = ARB_DATA;
          end
        end
      end
      ARB_DATA: begin
        data_ok_raw = bus_data_ok;
        if (bus_data_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, owner, streak and latched bus fields; reset also clears the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_INST;
      streak_q    <= '0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Route handshakes to the current owner only.
  assign inst_addr_ok = addr_ok_raw && (owner_q == OWNER_INST);
  assign data_addr_ok = addr_ok_raw && (owner_q == OWNER_DATA);
  assign inst_data_ok = data_ok_raw && (owner_q == OWNER_INST);
  assign data_data_ok = data_ok_raw && (owner_q == OWNER_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run scored against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } fields_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_wstrb;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  // {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}
  function automatic logic [5:0] dut_ctl();
    return {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy};
  endfunction

  function automatic fields_t dut_fields();
    return {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata};
  endfunction

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the falling edge (outputs are sampled here).
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wstrb  = 4'h0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    checks++;
    if (dut_ctl() !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want %b", dut_ctl(), 6'b0);
    end
    checks++;
    if ({bus_wr, dut_fields()} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", dut_fields());
    end
    rst = 1'b0;
    step();
    sample();
    checks++;
    if (dut_ctl() !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", dut_ctl(), 6'b0);
    end
  endtask

  task automatic test_inst_fetch();
    step();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    step();
    bus_addr_ok = 1'b1;
    sample();
    checks++;
    if (dut_ctl() !== 6'b110001) begin
      errors++;
      $display("FAIL fetch_c1_ctl: got %b want %b", dut_ctl(), 6'b110001);
    end
    checks++;
    if (dut_fields() !== {1'b0, 2'd2, 32'hBFC0_0000, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL fetch_c1_fields: got %h", dut_fields());
    end
    step();
    inst_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h3C08_0001;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000101) begin
      errors++;
      $display("FAIL fetch_c2_ctl: got %b want %b", dut_ctl(), 6'b000101);
    end
    checks++;
    if (inst_rdata !== 32'h3C08_0001) begin
      errors++;
      $display("FAIL fetch_rdata: got %h want %h", inst_rdata, 32'h3C08_0001);
    end
    step();
    bus_data_ok = 1'b0;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000000) begin
      errors++;
      $display("FAIL fetch_c3_idle: got %b want %b", dut_ctl(), 6'b000000);
    end
  endtask

  task automatic test_store_priority();
    step();
    inst_req   = 1'b1;
    inst_addr  = 32'h0040_0000;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd0;
    data_addr  = 32'h8000_1000;
    data_wstrb = 4'b0001;
    data_wdata = 32'h0000_00AB;
    step();
    bus_addr_ok = 1'b1;
    sample();
    checks++;
    if (dut_ctl() !== 6'b101001) begin
      errors++;
      $display("FAIL prio_c1_ctl: got %b want %b", dut_ctl(), 6'b101001);
    end
    checks++;
    if (dut_fields() !== {1'b1, 2'd0, 32'h8000_1000, 4'b0001, 32'h0000_00AB}) begin
      errors++;
      $display("FAIL prio_store_fields: got %h", dut_fields());
    end
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000011) begin
      errors++;
      $display("FAIL prio_c2_ctl: got %b want %b", dut_ctl(), 6'b000011);
    end
    step();
    bus_data_ok = 1'b0;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000000) begin
      errors++;
      $display("FAIL prio_bubble: got %b want %b", dut_ctl(), 6'b000000);
    end
    step();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h1234_5678;
    sample();
    checks++;
    if (dut_ctl() !== 6'b110101) begin
      errors++;
      $display("FAIL prio_inst_ctl: got %b want %b", dut_ctl(), 6'b110101);
    end
    checks++;
    if (dut_fields() !== {1'b0, 2'd2, 32'h0040_0000, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL prio_inst_fields: got %h", dut_fields());
    end
    step();
    inst_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    sample();
  endtask

  task automatic test_starvation();
    int  n;
    int  cyc;
    logic exp_inst;
    step();
    inst_req    = 1'b1;
    inst_addr   = 32'h0040_0100;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h8000_2000;
    data_wstrb  = 4'hF;
    data_wdata  = '0;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    n   = 0;
    cyc = 0;
    // With both ports hammering, every fifth grant must go to inst.
    while (n < 10 && cyc < 60) begin
      sample();
      if (inst_addr_ok || data_addr_ok) begin
        exp_inst = ((n % (LIMIT + 1)) == LIMIT);
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst}) begin
          errors++;
          $display("FAIL starve_grant%0d: got inst=%b data=%b want inst=%b",
                   n, inst_addr_ok, data_addr_ok, exp_inst);
        end
        n++;
      end
      step();
      cyc++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants want 10", n);
    end
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    step();
  endtask

  task automatic test_same_cycle_ok();
    step();
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd1;
    data_addr  = 32'h8000_3002;
    data_wstrb = 4'b1100;
    data_wdata = 32'hDEAD_BEEF;
    step();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hFFFF_0000;
    sample();
    checks++;
    if (dut_ctl() !== 6'b100001) begin
      errors++;
      $display("FAIL same_stray_dok: got %b want %b", dut_ctl(), 6'b100001);
    end
    step();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_5A5A;
    sample();
    checks++;
    if (dut_ctl() !== 6'b101011) begin
      errors++;
      $display("FAIL same_cycle_ctl: got %b want %b", dut_ctl(), 6'b101011);
    end
    checks++;
    if (data_rdata !== 32'h0000_5A5A) begin
      errors++;
      $display("FAIL same_cycle_rdata: got %h want %h", data_rdata, 32'h0000_5A5A);
    end
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000000) begin
      errors++;
      $display("FAIL same_cycle_idle: got %b want %b", dut_ctl(), 6'b000000);
    end
  endtask

  task automatic test_addr_stall();
    step();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0040;
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_4000;
        data_wstrb = 4'hF;
        data_wdata = 32'h1111_2222;
      end
      bus_addr_ok = 1'b0;
      bus_data_ok = k[0];
      sample();
      checks++;
      if (dut_ctl() !== 6'b100001) begin
        errors++;
        $display("FAIL stall%0d_ctl: got %b want %b", k, dut_ctl(), 6'b100001);
      end
      checks++;
      if (dut_fields() !== {1'b0, 2'd2, 32'hBFC0_0040, 4'h0, 32'h0}) begin
        errors++;
        $display("FAIL stall%0d_fields: got %h", k, dut_fields());
      end
      step();
    end
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b0;
    sample();
    checks++;
    if (dut_ctl() !== 6'b110001) begin
      errors++;
      $display("FAIL stall_accept: got %b want %b", dut_ctl(), 6'b110001);
    end
    step();
    inst_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h2400_0001;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000101 || inst_rdata !== 32'h2400_0001) begin
      errors++;
      $display("FAIL stall_data: got %b/%h want %b/%h", dut_ctl(), inst_rdata,
               6'b000101, 32'h2400_0001);
    end
    step();
    bus_data_ok = 1'b0;
    sample();
    checks++;
    if (dut_ctl() !== 6'b000000) begin
      errors++;
      $display("FAIL stall_bubble: got %b want %b", dut_ctl(), 6'b000000);
    end
    step();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    sample();
    checks++;
    if (dut_ctl() !== 6'b101011) begin
      errors++;
      $display("FAIL stall_late_data_ctl: got %b want %b", dut_ctl(), 6'b101011);
    end
    checks++;
    if (dut_fields() !== {1'b1, 2'd2, 32'h8000_4000, 4'hF, 32'h1111_2222}) begin
      errors++;
      $display("FAIL stall_late_data_fields: got %h", dut_fields());
    end
    step();
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    sample();
  endtask

  task automatic test_async_reset();
    step();
    inst_req   = 1'b1;
    inst_addr  = 32'h0040_0200;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h8000_5000;
    data_wstrb = 4'hF;
    data_wdata = 32'hCAFE_F00D;
    // Four data grants while inst waits bring the streak to its limit.
    for (int t = 0; t < 4; t++) begin
      step();
      bus_addr_ok = 1'b1;
      bus_data_ok = 1'b0;
      sample();
      checks++;
      if (dut_ctl() !== 6'b101001) begin
        errors++;
        $display("FAIL rst_pre%0d_addr: got %b want %b", t, dut_ctl(), 6'b101001);
      end
      step();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1;
      if (t < 3) begin
        sample();
        step();
        bus_data_ok = 1'b0;
      end
    end
    // Mid-cycle in DATA with bus_data_ok high: reset must silence everything.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_ctl() !== 6'b000000) begin
      errors++;
      $display("FAIL rst_async_ctl: got %b want %b", dut_ctl(), 6'b000000);
    end
    checks++;
    if (dut_fields() !== '0) begin
      errors++;
      $display("FAIL rst_async_fields: got %h want 0", dut_fields());
    end
    bus_data_ok = 1'b0;
    step();
    rst = 1'b0;
    // Streak was cleared, so data wins again despite inst waiting.
    step();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    sample();
    checks++;
    if (dut_ctl() !== 6'b101011) begin
      errors++;
      $display("FAIL rst_regrant_ctl: got %b want %b", dut_ctl(), 6'b101011);
    end
    checks++;
    if (dut_fields() !== {1'b1, 2'd2, 32'h8000_5000, 4'hF, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL rst_regrant_fields: got %h", dut_fields());
    end
    step();
    clear_inputs();
    step();
  endtask

  // Randomized traffic from both ports and a bus with random latencies,
  // scored against a transaction-level model of the arbitration rules.
  task automatic test_random();
    bit      m_in_flight, m_accepted, m_done_prev, m_owner_inst;
    int      m_streak;
    bit      prev_i, prev_d, i_pend, d_pend, i_acc, d_acc;
    bit      exp_req, exp_aok, exp_dok, grant_i;
    fields_t m_fields, d_fields;
    logic [5:0] exp_ctl;

    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    m_in_flight = 0; m_accepted = 0; m_done_prev = 0; m_owner_inst = 0;
    m_streak = 0; prev_i = 0; prev_d = 0; i_pend = 0; d_pend = 0;
    i_acc = 0; d_acc = 0;
    m_fields = '0;
    d_fields = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      // Effect of the edge that just happened.
      if (m_in_flight) begin
        if (m_done_prev) m_in_flight = 0;
      end else begin
        if (prev_i || prev_d) begin
          grant_i = prev_i && (!prev_d || m_streak == LIMIT);
          if (grant_i) begin
            m_fields = {1'b0, 2'd2, inst_addr, 4'h0, 32'h0};
            m_streak = 0;
          end else begin
            m_fields = d_fields;
            if (prev_i && m_streak < LIMIT) m_streak++;
          end
          m_owner_inst = grant_i;
          m_in_flight  = 1;
          m_accepted   = 0;
        end
        if (!prev_i) m_streak = 0;
      end

      // Requesters: drop after acceptance, occasionally raise a new request.
      if (i_acc) i_pend = 0;
      if (d_acc) d_pend = 0;
      if (!i_pend) begin
        inst_addr = 32'($urandom) & 32'hFFFF_FFFC;
        if ($urandom_range(3, 0) == 0) i_pend = 1;
      end
      if (!d_pend) begin
        d_fields.wr    = 1'($urandom_range(1, 0));
        d_fields.size  = 2'($urandom_range(2, 0));
        d_fields.addr  = 32'($urandom);
        d_fields.wstrb = 4'($urandom_range(15, 0));
        d_fields.wdata = 32'($urandom);
        if ($urandom_range(2, 0) == 0) d_pend = 1;
      end
      inst_req   = i_pend;
      data_req   = d_pend;
      data_wr    = d_fields.wr;
      data_size  = d_fields.size;
      data_addr  = d_fields.addr;
      data_wstrb = d_fields.wstrb;
      data_wdata = d_fields.wdata;

      // Bus responder with random accept/return delays.
      bus_rdata = 32'($urandom);
      if (m_in_flight && !m_accepted) begin
        bus_addr_ok = ($urandom_range(2, 0) == 0);
        bus_data_ok = 1'($urandom_range(1, 0));
      end else if (m_in_flight) begin
        bus_addr_ok = 1'b0;
        bus_data_ok = ($urandom_range(2, 0) == 0);
      end else begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
      end

      sample();
      exp_req = m_in_flight && !m_accepted;
      exp_aok = exp_req && bus_addr_ok;
      exp_dok = m_in_flight && (m_accepted ? bus_data_ok : (bus_addr_ok && bus_data_ok));
      exp_ctl = {exp_req, exp_aok && m_owner_inst, exp_aok && !m_owner_inst,
                 exp_dok && m_owner_inst, exp_dok && !m_owner_inst, m_in_flight};
      checks++;
      if (dut_ctl() !== exp_ctl) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d: got %b want %b", cyc, dut_ctl(), exp_ctl);
      end
      if (exp_req) begin
        checks++;
        if (dut_fields() !== m_fields) begin
          errors++;
          $display("FAIL rand_fields cyc%0d: got %h want %h", cyc, dut_fields(), m_fields);
        end
      end
      if (exp_dok) begin
        checks++;
        if ((m_owner_inst ? inst_rdata : data_rdata) !== bus_rdata) begin
          errors++;
          $display("FAIL rand_rdata cyc%0d: got %h want %h", cyc,
                   m_owner_inst ? inst_rdata : data_rdata, bus_rdata);
        end
      end
      i_acc = exp_aok && m_owner_inst;
      d_acc = exp_aok && !m_owner_inst;
      if (exp_aok && !exp_dok) m_accepted = 1;
      m_done_prev = exp_dok;
      prev_i = inst_req;
      prev_d = data_req;
    end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_store_priority();
    test_starvation();
    test_same_cycle_ok();
    test_addr_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
